// File: rtl/conv_tile_scheduler_pkg.sv
// Shared types and default geometry for the conv tile scheduler.
// Tags carry tile origin coordinates through the array pipeline.
package conv_pkg;

  localparam int IMG_H    = 416;
  localparam int IMG_W    = 416;
  localparam int TILE     = 4;
  localparam int IN_CH    = 3;
  localparam int CONV_LAT = 2;
  localparam int COORD_W  = 9;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  typedef struct packed {
    logic               valid;
    logic               last_ch;
    logic [COORD_W-1:0] row;
    logic [COORD_W-1:0] col;
  } tile_tag_t;

  // Counter width for n distinct values, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/conv_tile_scheduler_if.sv
// Handshake and status bundle between the scheduler and its environment.
// master = scheduler side, slave = line buffer / writeback / control side.
interface conv_tile_scheduler_if #(
  parameter int COORD_W = conv_pkg::COORD_W
);

  logic               start_i;
  logic               busy_o;
  logic               done_o;
  logic               fetch_valid_o;
  logic               fetch_ready_i;
  logic [COORD_W-1:0] fetch_row_o;
  logic [COORD_W-1:0] fetch_col_o;
  logic [1:0]         fetch_ch_o;
  logic               arr_ce_o;
  logic               arr_launch_o;
  logic               arr_first_o;
  logic               wr_valid_o;
  logic               wr_ready_i;
  logic [COORD_W-1:0] wr_row_o;
  logic [COORD_W-1:0] wr_col_o;
  logic [31:0]        stall_cnt_o;

  modport master (
    input  start_i, fetch_ready_i, wr_ready_i,
    output busy_o, done_o, fetch_valid_o, fetch_row_o, fetch_col_o, fetch_ch_o,
           arr_ce_o, arr_launch_o, arr_first_o, wr_valid_o, wr_row_o, wr_col_o,
           stall_cnt_o
  );

  modport slave (
    output start_i, fetch_ready_i, wr_ready_i,
    input  busy_o, done_o, fetch_valid_o, fetch_row_o, fetch_col_o, fetch_ch_o,
           arr_ce_o, arr_launch_o, arr_first_o, wr_valid_o, wr_row_o, wr_col_o,
           stall_cnt_o
  );

endinterface

// File: rtl/conv_tile_scheduler_tag_pipe.sv
// LAT-deep tag shift register mirroring the array pipeline; shifts only with ce.
// Latency LAT enabled cycles; frozen (no shift, no loss) while ce is low.
module conv_tag_pipe
  import conv_pkg::*;
#(
  parameter int LAT = conv_pkg::CONV_LAT
) (
  input  logic      clk_i,
  input  logic      rst_i,
  input  logic      ce,
  input  tile_tag_t load_tag,
  output tile_tag_t final_tag,
  output logic      upstream_vld
);

  tile_tag_t stage [LAT];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < LAT; i++) stage[i] <= '0;
    end else if (ce) begin
      stage[0] <= load_tag;
      for (int i = 1; i < LAT; i++) stage[i] <= stage[i-1];
    end
  end

  // Anything still travelling behind the final stage keeps DRAIN alive.
  always_comb begin
    upstream_vld = 1'b0;
    for (int i = 0; i < LAT - 1; i++) upstream_vld = upstream_vld | stage[i].valid;
  end

  assign final_tag = stage[LAT-1];

endmodule

// File: rtl/conv_tile_scheduler.sv
// Walks channels, tile columns, tile rows; one array launch per (tile, channel).
// Results emerge CONV_LAT enabled cycles after the last-channel launch; a refused writeback freezes everything.
module conv_tile_scheduler
  import conv_pkg::*;
#(
  parameter int IMG_H    = conv_pkg::IMG_H,
  parameter int IMG_W    = conv_pkg::IMG_W,
  parameter int TILE     = conv_pkg::TILE,
  parameter int IN_CH    = conv_pkg::IN_CH,
  parameter int CONV_LAT = conv_pkg::CONV_LAT,
  parameter int COORD_W  = conv_pkg::COORD_W
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  conv_tile_scheduler_if.master  bus
);

  localparam int TILES_X = IMG_W / TILE;
  localparam int TILES_Y = IMG_H / TILE;
  localparam int TX_W    = cnt_w(TILES_X);
  localparam int TY_W    = cnt_w(TILES_Y);
  localparam int TAG_CW  = conv_pkg::COORD_W;

  localparam logic [TX_W-1:0] TX_MAX = TX_W'(TILES_X - 1);
  localparam logic [TY_W-1:0] TY_MAX = TY_W'(TILES_Y - 1);
  localparam logic [1:0]      CH_MAX = 2'(IN_CH - 1);

  state_t            state, state_nxt;
  logic [TX_W-1:0]   tx;
  logic [TY_W-1:0]   ty;
  logic [1:0]        ch;
  logic [31:0]       stall_cnt;

  logic              busy, done, fetch_vld;
  logic              ce, wr_vld, launch, last_launch, start_acc, drain_done;
  logic              upstream_vld;
  logic [COORD_W-1:0] fetch_row, fetch_col;
  tile_tag_t         launch_tag, final_tag;

  // Only a tile that is presented but refused holds the array.
  assign wr_vld      = final_tag.valid && final_tag.last_ch;
  assign ce          = !(wr_vld && !bus.wr_ready_i);
  assign launch      = fetch_vld && bus.fetch_ready_i;
  assign last_launch = launch && (ch == CH_MAX) && (tx == TX_MAX) && (ty == TY_MAX);
  assign start_acc   = (state == IDLE) && bus.start_i;
  assign drain_done  = !upstream_vld && (!wr_vld || bus.wr_ready_i);

  assign fetch_row = COORD_W'(ty) * COORD_W'(TILE);
  assign fetch_col = COORD_W'(tx) * COORD_W'(TILE);

  always_ff @(posedge clk_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start_i) state_nxt = RUN;
      RUN:     if (last_launch) state_nxt = DRAIN;
      DRAIN:   if (drain_done)  state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy      = (state == RUN) || (state == DRAIN);
    done      = (state == DONE);
    fetch_vld = (state == RUN) && ce;
  end

  // Channel is the innermost loop, then tile column, then tile row.
  always_ff @(posedge clk_i) begin
    if (rst_i || start_acc) begin
      ch <= '0;
      tx <= '0;
      ty <= '0;
    end else if (launch) begin
      if (ch == CH_MAX) begin
        ch <= '0;
        if (tx == TX_MAX) begin
          tx <= '0;
          ty <= (ty == TY_MAX) ? '0 : ty + TY_W'(1);
        end else begin
          tx <= tx + TX_W'(1);
        end
      end else begin
        ch <= ch + 2'd1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || start_acc)                  stall_cnt <= '0;
    else if (busy && !ce && stall_cnt != '1) stall_cnt <= stall_cnt + 32'd1;
  end

  always_comb begin
    launch_tag = '0;
    if (launch) begin
      launch_tag.valid   = 1'b1;
      launch_tag.last_ch = (ch == CH_MAX);
      launch_tag.row     = TAG_CW'(fetch_row);
      launch_tag.col     = TAG_CW'(fetch_col);
    end
  end

  conv_tag_pipe #(
    .LAT (CONV_LAT)
  ) u_tag_pipe (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .ce           (ce),
    .load_tag     (launch_tag),
    .final_tag    (final_tag),
    .upstream_vld (upstream_vld)
  );

  assign bus.busy_o        = busy;
  assign bus.done_o        = done;
  assign bus.fetch_valid_o = fetch_vld;
  assign bus.fetch_row_o   = fetch_row;
  assign bus.fetch_col_o   = fetch_col;
  assign bus.fetch_ch_o    = ch;
  assign bus.arr_ce_o      = ce;
  assign bus.arr_launch_o  = launch;
  assign bus.arr_first_o   = launch && (ch == 2'd0);
  assign bus.wr_valid_o    = wr_vld;
  assign bus.wr_row_o      = COORD_W'(final_tag.row);
  assign bus.wr_col_o      = COORD_W'(final_tag.col);
  assign bus.stall_cnt_o   = stall_cnt;

endmodule

// File: tb/tb_conv_tile_scheduler.sv
// Directed bench for conv_tile_scheduler on an 8x8 map (4 tiles x 3 channels).
module tb_conv_tile_scheduler;

  localparam int IMG_H    = 8;
  localparam int IMG_W    = 8;
  localparam int TILE     = 4;
  localparam int IN_CH    = 3;
  localparam int CONV_LAT = 2;
  localparam int COORD_W  = 9;
  localparam int NL       = (IMG_H / TILE) * (IMG_W / TILE) * IN_CH;
  localparam int NT       = (IMG_H / TILE) * (IMG_W / TILE);

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;

  conv_tile_scheduler_if #(.COORD_W(COORD_W)) bus ();

  conv_tile_scheduler #(
    .IMG_H(IMG_H), .IMG_W(IMG_W), .TILE(TILE), .IN_CH(IN_CH),
    .CONV_LAT(CONV_LAT), .COORD_W(COORD_W)
  ) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Launch order from the loop nest: rows outermost, channel innermost.
  int seq_row [NL];
  int seq_col [NL];
  int seq_ch  [NL];

  typedef struct {
    int row;
    int col;
    int due;
  } pend_t;

  pend_t       q[$];
  int          phase = 0;     // 0 idle, 1 run, 2 drain, 3 done
  int          ecnt  = 0;     // enabled cycles seen so far
  int          lcnt  = 0;
  logic [31:0] mstall = '0;

  int          cyc = 0;
  int          n_launch, n_done, n_xfer, n_ce_low, done_cyc;
  int          launch_cyc [NL];
  int          wr_cyc [NT];
  int          wr_row_seen [NT];
  int          wr_col_seen [NT];
  logic [NL-1:0] first_mask;

  always @(negedge clk_i) begin : compare
    logic e_wv, e_ce, e_fv, e_ln, e_busy, e_done, xfer;
    int   k;
    cyc++;
    k      = (lcnt < NL) ? lcnt : NL - 1;
    e_wv   = (q.size() > 0) && (ecnt == q[0].due);
    e_ce   = !(e_wv && !bus.wr_ready_i);
    e_fv   = (phase == 1) && e_ce;
    e_ln   = e_fv && bus.fetch_ready_i;
    e_busy = (phase == 1) || (phase == 2);
    e_done = (phase == 3);

    chk("wr_valid",   32'(bus.wr_valid_o),    32'(e_wv));
    chk("arr_ce",     32'(bus.arr_ce_o),      32'(e_ce));
    chk("fetch_valid",32'(bus.fetch_valid_o), 32'(e_fv));
    chk("arr_launch", 32'(bus.arr_launch_o),  32'(e_ln));
    chk("arr_first",  32'(bus.arr_first_o),   32'(e_ln && seq_ch[k] == 0));
    chk("busy",       32'(bus.busy_o),        32'(e_busy));
    chk("done",       32'(bus.done_o),        32'(e_done));
    chk("stall_cnt",  bus.stall_cnt_o,        mstall);
    if (e_fv) begin
      chk("fetch_row", 32'(bus.fetch_row_o), 32'(seq_row[k]));
      chk("fetch_col", 32'(bus.fetch_col_o), 32'(seq_col[k]));
      chk("fetch_ch",  32'(bus.fetch_ch_o),  32'(seq_ch[k]));
    end
    if (e_wv) begin
      chk("wr_row", 32'(bus.wr_row_o), 32'(q[0].row));
      chk("wr_col", 32'(bus.wr_col_o), 32'(q[0].col));
    end

    if (bus.arr_launch_o) begin
      if (n_launch < NL) begin
        launch_cyc[n_launch] = cyc;
        first_mask[n_launch] = bus.arr_first_o;
      end
      n_launch++;
    end
    if (bus.wr_valid_o && bus.wr_ready_i) begin
      if (n_xfer < NT) begin
        wr_cyc[n_xfer]      = cyc;
        wr_row_seen[n_xfer] = int'(bus.wr_row_o);
        wr_col_seen[n_xfer] = int'(bus.wr_col_o);
      end
      n_xfer++;
    end
    if (bus.done_o) begin
      done_cyc = cyc;
      n_done++;
    end
    if (!bus.arr_ce_o) n_ce_low++;

    xfer = e_wv && bus.wr_ready_i;
    if (rst_i) begin
      phase = 0; q.delete(); ecnt = 0; lcnt = 0; mstall = '0;
    end else begin
      if (e_busy && !e_ce && mstall != 32'hFFFF_FFFF) mstall = mstall + 32'd1;
      case (phase)
        0: if (bus.start_i) begin phase = 1; lcnt = 0; mstall = '0; end
        1: if (e_ln) begin
             if (seq_ch[k] == IN_CH - 1) q.push_back('{seq_row[k], seq_col[k], ecnt + CONV_LAT});
             lcnt++;
             if (lcnt == NL) phase = 2;
           end
        2: if (xfer && q.size() == 1) phase = 3;
        default: phase = 0;
      endcase
      if (xfer) q.delete(0);
      if (e_ce) ecnt++;
    end
  end

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic clear_obs();
    n_launch = 0; n_done = 0; n_xfer = 0; n_ce_low = 0; first_mask = '0; done_cyc = 0;
  endtask

  task automatic start_layer();
    bus.start_i = 1'b1;
    step();
    bus.start_i = 1'b0;
  endtask

  // toggle=1 flips fetch_ready_i every cycle while waiting.
  task automatic wait_done(input int budget, input bit toggle);
    int i;
    for (i = 0; i < budget && n_done == 0; i++) begin
      if (toggle) bus.fetch_ready_i = ~bus.fetch_ready_i;
      step();
    end
    chk("done_within_budget", 32'(n_done > 0), 32'd1);
    bus.fetch_ready_i = 1'b1;
    repeat (3) step();
  endtask

  task automatic chk_origins(input string tag);
    for (int t = 0; t < NT; t++) begin
      chk({tag, "_wr_row"}, 32'(wr_row_seen[t]), 32'((t / 2) * 4));
      chk({tag, "_wr_col"}, 32'(wr_col_seen[t]), 32'((t % 2) * 4));
    end
  endtask

  logic [NL-1:0] exp_first;

  initial begin : stim
    int n, i;
    n = 0;
    for (int ty = 0; ty < IMG_H / TILE; ty++)
      for (int tx = 0; tx < IMG_W / TILE; tx++)
        for (int c = 0; c < IN_CH; c++) begin
          seq_row[n] = ty * TILE; seq_col[n] = tx * TILE; seq_ch[n] = c; n++;
        end
    exp_first = 12'h249;
    clear_obs();
    bus.start_i = 1'b0; bus.fetch_ready_i = 1'b0; bus.wr_ready_i = 1'b1;
    rst_i = 1'b1;
    repeat (2) step();
    chk("rst_busy",  32'(bus.busy_o), 32'd0);
    chk("rst_done",  32'(bus.done_o), 32'd0);
    chk("rst_fv",    32'(bus.fetch_valid_o), 32'd0);
    chk("rst_wv",    32'(bus.wr_valid_o), 32'd0);
    chk("rst_stall", bus.stall_cnt_o, 32'd0);
    rst_i = 1'b0;
    step();

    // 1: full-rate layer; also pins arr_first_o positions.
    bus.fetch_ready_i = 1'b1; bus.wr_ready_i = 1'b1;
    clear_obs(); start_layer(); wait_done(100, 1'b0);
    chk("t1_launches",   32'(n_launch), 32'd12);
    chk("t1_xfers",      32'(n_xfer), 32'd4);
    chk("t1_dones",      32'(n_done), 32'd1);
    chk("t1_b2b",        32'(launch_cyc[11] - launch_cyc[0]), 32'd11);
    chk("t1_latency",    32'(wr_cyc[0] - launch_cyc[2]), 32'd2);
    chk("t1_done_after", 32'(done_cyc - wr_cyc[3]), 32'd1);
    chk("t1_stall",      bus.stall_cnt_o, 32'd0);
    chk("t1_ce_low",     32'(n_ce_low), 32'd0);
    chk("t4_first_mask", 32'(first_mask), 32'(exp_first));
    chk_origins("t1");

    // 2: fetch_ready_i toggling.
    clear_obs(); start_layer(); wait_done(200, 1'b1);
    chk("t2_launches", 32'(n_launch), 32'd12);
    chk("t2_dones",    32'(n_done), 32'd1);
    chk("t2_spacing",  32'(launch_cyc[1] - launch_cyc[0]), 32'd2);
    chk_origins("t2");

    // 3: writeback refuses the first tile for 5 cycles.
    bus.wr_ready_i = 1'b0;
    clear_obs(); start_layer();
    for (i = 0; i < 50 && !bus.wr_valid_o; i++) step();
    chk("t3_wv_seen", 32'(bus.wr_valid_o), 32'd1);
    repeat (5) step();
    bus.wr_ready_i = 1'b1;
    wait_done(100, 1'b0);
    chk("t3_stall",     bus.stall_cnt_o, 32'd5);
    chk("t3_ce_low",    32'(n_ce_low), 32'd5);
    chk("t3_launches",  32'(n_launch), 32'd12);
    chk("t3_first_wr",  32'(wr_row_seen[0] + wr_col_seen[0]), 32'd0);
    chk_origins("t3");

    // 5: reset mid-run, reset beats a coincident start, then a clean replay.
    clear_obs(); start_layer();
    for (i = 0; i < 50 && n_launch < 7; i++) step();
    rst_i = 1'b1;
    step();
    chk("t5_busy",  32'(bus.busy_o), 32'd0);
    chk("t5_fv",    32'(bus.fetch_valid_o), 32'd0);
    chk("t5_ln",    32'(bus.arr_launch_o), 32'd0);
    chk("t5_wv",    32'(bus.wr_valid_o), 32'd0);
    chk("t5_row",   32'(bus.fetch_row_o), 32'd0);
    chk("t5_col",   32'(bus.fetch_col_o), 32'd0);
    chk("t5_ch",    32'(bus.fetch_ch_o), 32'd0);
    chk("t5_wrrow", 32'(bus.wr_row_o), 32'd0);
    bus.start_i = 1'b1;
    step();
    bus.start_i = 1'b0; rst_i = 1'b0;
    step();
    chk("t5_start_in_rst", 32'(bus.busy_o), 32'd0);
    clear_obs(); start_layer(); wait_done(100, 1'b0);
    chk("t5_launches", 32'(n_launch), 32'd12);
    chk("t5_dones",    32'(n_done), 32'd1);
    chk_origins("t5");

    // 6: start pulses in RUN and DONE are ignored.
    clear_obs(); start_layer();
    repeat (3) step();
    bus.start_i = 1'b1; step(); bus.start_i = 1'b0;
    for (i = 0; i < 100 && !bus.done_o; i++) step();
    chk("t6_done_seen", 32'(bus.done_o), 32'd1);
    bus.start_i = 1'b1; step(); bus.start_i = 1'b0;
    repeat (20) step();
    chk("t6_dones",    32'(n_done), 32'd1);
    chk("t6_launches", 32'(n_launch), 32'd12);
    chk("t6_idle",     32'(bus.busy_o), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not finish, errors %0d", n_errors);
    $fatal(1);
  end

endmodule
